note_sequencer: RTL and testbench

Sequencer for the 64-entry x 32-bit note memory of the guitar recorder. It takes the beat tick from the clock divider and captured chord words from the coordinate converter. In record mode it writes one word per beat at incrementing addresses and tracks the recorded length. In play mode it reads the words back one per beat and hands each to the audio/display consumer over a valid/ready handshake, optionally looping.

---
 rtl/note_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_note_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Record/playback sequencer for the guitar recorder's note memory.
// Records one note word per beat; plays them back over a valid/ready handshake.
module note_sequencer #(
  parameter int ADDR_W = 6,
  parameter int NOTE_W = 32
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_start_rec,
  input  logic              i_start_play,
  input  logic              i_stop,
  input  logic              i_loop,
  input  logic              i_beat,
  input  logic [NOTE_W-1:0] i_note_in,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wren,
  output logic [NOTE_W-1:0] o_mem_wdata,
  input  logic [NOTE_W-1:0] i_mem_rdata,
  output logic [NOTE_W-1:0] o_note_out,
  output logic              o_note_valid,
  input  logic              i_note_ready,
  output logic [ADDR_W:0]   o_rec_len,
  output logic              o_missed,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REC     = 3'd1,
    S_P_WAIT  = 3'd2,
    S_P_FETCH = 3'd3,
    S_P_LOAD  = 3'd4,
    S_P_OUT   = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ONE_A = 1;
  localparam logic [ADDR_W:0]   ONE_L = 1;
  localparam logic [ADDR_W:0]   FULL  = ONE_L << ADDR_W;

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_wptr, w_wptr_next;
  logic [ADDR_W-1:0]   r_rptr, w_rptr_next;
  logic [ADDR_W:0]     r_rec_len, w_rec_len_next;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_next;
  logic                r_mem_wren, w_mem_wren_next;
  logic [NOTE_W-1:0]   r_mem_wdata, w_mem_wdata_next;
  logic [NOTE_W-1:0]   r_note_out, w_note_out_next;
  logic                r_note_valid, w_note_valid_next;
  logic                r_missed, w_missed_next;
  logic [ADDR_W:0]     w_rec_len_inc;
  logic [ADDR_W:0]     w_rptr_inc_ext;

  assign w_rec_len_inc  = r_rec_len + ONE_L;
  assign w_rptr_inc_ext = {1'b0, r_rptr} + ONE_L;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_rec_len    <= '0;
      r_mem_addr   <= '0;
      r_mem_wren   <= 1'b0;
      r_mem_wdata  <= '0;
      r_note_out   <= '0;
      r_note_valid <= 1'b0;
      r_missed     <= 1'b0;
    end else begin
      r_wptr       <= w_wptr_next;
      r_rptr       <= w_rptr_next;
      r_rec_len    <= w_rec_len_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_wren   <= w_mem_wren_next;
      r_mem_wdata  <= w_mem_wdata_next;
      r_note_out   <= w_note_out_next;
      r_note_valid <= w_note_valid_next;
      r_missed     <= w_missed_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_wptr_next       = r_wptr;
    w_rptr_next       = r_rptr;
    w_rec_len_next    = r_rec_len;
    w_mem_addr_next   = r_mem_addr;
    w_mem_wren_next   = 1'b0;
    w_mem_wdata_next  = r_mem_wdata;
    w_note_out_next   = r_note_out;
    w_note_valid_next = r_note_valid;
    w_missed_next     = r_missed;

    case (r_state)
      S_IDLE: begin
        w_note_valid_next = 1'b0;
        if (i_start_rec) begin
          w_state_next   = S_REC;
          w_wptr_next    = '0;
          w_rec_len_next = '0;
        end else if (i_start_play && (r_rec_len != '0)) begin
          w_state_next  = S_P_WAIT;
          w_rptr_next   = '0;
          w_missed_next = 1'b0;
        end
      end
      S_REC: begin
        // A beat coinciding with stop still commits its write before leaving.
        if (i_beat) begin
          w_mem_addr_next  = r_wptr;
          w_mem_wdata_next = i_note_in;
          w_mem_wren_next  = 1'b1;
          w_wptr_next      = r_wptr + ONE_A;
          w_rec_len_next   = w_rec_len_inc;
          if (w_rec_len_inc == FULL) w_state_next = S_IDLE;
        end
        if (i_stop) w_state_next = S_IDLE;
      end
      S_P_WAIT: begin
        if (i_stop) begin
          w_state_next = S_IDLE;
        end else if (i_beat) begin
          w_mem_addr_next = r_rptr;
          w_state_next    = S_P_FETCH;
        end
      end
      S_P_FETCH: begin
        w_state_next = i_stop ? S_IDLE : S_P_LOAD;
      end
      S_P_LOAD: begin
        if (i_stop) begin
          w_state_next = S_IDLE;
        end else begin
          w_note_out_next   = i_mem_rdata;
          w_note_valid_next = 1'b1;
          w_state_next      = S_P_OUT;
        end
      end
      S_P_OUT: begin
        if (i_stop) begin
          w_state_next      = S_IDLE;
          w_note_valid_next = 1'b0;
        end else if (r_note_valid && i_note_ready) begin
          w_note_valid_next = 1'b0;
          w_rptr_next       = r_rptr + ONE_A;
          if (w_rptr_inc_ext == r_rec_len) begin
            if (i_loop) begin
              w_rptr_next  = '0;
              w_state_next = S_P_WAIT;
            end else begin
              w_state_next = S_IDLE;
            end
          end else begin
            w_state_next = S_P_WAIT;
          end
        end
      end
      default: begin
        w_state_next      = S_IDLE;
        w_note_valid_next = 1'b0;
      end
    endcase

    // Beats arriving while a note is still in flight are lost.
    if (i_beat && (r_state == S_P_FETCH || r_state == S_P_LOAD || r_state == S_P_OUT))
      w_missed_next = 1'b1;
  end

  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wren   = r_mem_wren;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_note_out   = r_note_out;
  assign o_note_valid = r_note_valid;
  assign o_rec_len    = r_rec_len;
  assign o_missed     = r_missed;
  assign o_state      = r_state;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: a queue of recorded notes is the
// reference; a registered-read RAM model stands in for the note memory.
module tb_note_sequencer;

  logic        clk;
  logic        resetn;
  logic        start_rec, start_play, stop, loop, beat, note_ready;
  logic [31:0] note_in;
  logic [5:0]  mem_addr;
  logic        mem_wren;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] note_out;
  logic        note_valid;
  logic [6:0]  rec_len;
  logic        missed;
  logic [2:0]  state;

  logic [31:0] ram [64];

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rec[$];
  int play_idx = 0;

  note_sequencer #(.ADDR_W(6), .NOTE_W(32)) dut (
    .i_clk        (clk),
    .i_resetn     (resetn),
    .i_start_rec  (start_rec),
    .i_start_play (start_play),
    .i_stop       (stop),
    .i_loop       (loop),
    .i_beat       (beat),
    .i_note_in    (note_in),
    .o_mem_addr   (mem_addr),
    .o_mem_wren   (mem_wren),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata),
    .o_note_out   (note_out),
    .o_note_valid (note_valid),
    .i_note_ready (note_ready),
    .o_rec_len    (rec_len),
    .o_missed     (missed),
    .o_state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rec_beat(input logic [31:0] n);
    int idx;
    idx = exp_rec.size();
    note_in = n;
    beat = 1'b1;
    step();
    beat = 1'b0;
    chk("rec_wren", mem_wren, 1);
    chk("rec_addr", mem_addr, idx);
    chk("rec_data", mem_wdata, n);
    exp_rec.push_back(n);
    chk("rec_len", rec_len, exp_rec.size());
    $display("rec beat %0d: addr=%0d data=%08h rec_len=%0d", idx, mem_addr, mem_wdata, rec_len);
    step();
    chk("rec_wren_off", mem_wren, 0);
  endtask

  task automatic do_start_rec();
    exp_rec.delete();
    start_rec = 1'b1;
    step();
    start_rec = 1'b0;
    chk("start_rec_state", state, 1);
  endtask

  task automatic do_start_play();
    play_idx = 0;
    start_play = 1'b1;
    step();
    start_play = 1'b0;
    chk("start_play_state", state, 2);
    chk("start_play_missed", missed, 0);
  endtask

  // One beat with note_ready high: the note should appear 3 cycles after the beat.
  task automatic play_beat();
    logic [31:0] exp_note;
    int exp_state;
    exp_note = exp_rec[play_idx];
    play_idx++;
    exp_state = 2;
    if (play_idx == exp_rec.size()) begin
      if (loop) play_idx = 0;
      else exp_state = 0;
    end
    beat = 1'b1;
    step();
    beat = 1'b0;
    chk("play_fetch_state", state, 3);
    step();
    chk("play_valid_early", note_valid, 0);
    step();
    chk("play_valid", note_valid, 1);
    chk("play_note", note_out, exp_note);
    $display("play: note_out=%08h expected=%08h", note_out, exp_note);
    step();
    chk("play_valid_drop", note_valid, 0);
    chk("play_next_state", state, exp_state);
  endtask

  initial begin
    resetn = 1'b0; start_rec = 1'b0; start_play = 1'b0; stop = 1'b0;
    loop = 1'b0; beat = 1'b0; note_ready = 1'b1; note_in = '0;
    repeat (3) step();
    resetn = 1'b1;
    step();
    chk("rst_state", state, 0);
    chk("rst_valid", note_valid, 0);
    chk("rst_rec_len", rec_len, 0);
    chk("rst_missed", missed, 0);
    chk("rst_wren", mem_wren, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_note_out", note_out, 0);

    // Directed three-note recording.
    do_start_rec();
    rec_beat(32'h1);
    rec_beat(32'h40);
    rec_beat(32'h2000);
    stop = 1'b1; step(); stop = 1'b0;
    chk("rec_stop_state", state, 0);
    chk("rec_stop_len", rec_len, 3);

    // Play once without looping.
    loop = 1'b0; note_ready = 1'b1;
    do_start_play();
    repeat (3) play_beat();
    chk("play_missed", missed, 0);

    // Looping playback of five beats.
    loop = 1'b1;
    do_start_play();
    repeat (5) play_beat();
    chk("loop_missed", missed, 0);
    stop = 1'b1; step(); stop = 1'b0;
    chk("loop_stop_state", state, 0);
    chk("loop_stop_valid", note_valid, 0);
    chk("loop_stop_len", rec_len, 3);

    // Fill all 64 entries with random notes; memory full returns to IDLE.
    do_start_rec();
    for (int i = 0; i < 64; i++) rec_beat($urandom);
    chk("full_state", state, 0);
    chk("full_len", rec_len, 64);
    beat = 1'b1; note_in = $urandom; step(); beat = 1'b0;
    chk("beat65_wren", mem_wren, 0);
    chk("beat65_len", rec_len, 64);

    // Stalled consumer: a beat during the stall is missed, note_out holds.
    loop = 1'b0; note_ready = 1'b0;
    do_start_play();
    beat = 1'b1; step(); beat = 1'b0;
    step(); step();
    chk("stall_valid", note_valid, 1);
    chk("stall_note", note_out, exp_rec[0]);
    repeat (4) step();
    beat = 1'b1; step(); beat = 1'b0;
    repeat (5) step();
    chk("stall_hold_valid", note_valid, 1);
    chk("stall_hold_note", note_out, exp_rec[0]);
    chk("stall_missed", missed, 1);
    chk("stall_state", state, 5);
    note_ready = 1'b1;
    step();
    chk("stall_accept_valid", note_valid, 0);
    chk("stall_accept_state", state, 2);
    play_idx = 1;
    play_beat();
    stop = 1'b1; step(); stop = 1'b0;
    chk("stall_stop_state", state, 0);
    do_start_play();

    stop = 1'b1; step(); stop = 1'b0;
    // Stop together with a beat while recording still commits the write.
    do_start_rec();
    rec_beat($urandom);
    rec_beat($urandom);
    note_in = $urandom;
    stop = 1'b1; beat = 1'b1;
    step();
    stop = 1'b0; beat = 1'b0;
    chk("stopbeat_wren", mem_wren, 1);
    chk("stopbeat_addr", mem_addr, 2);
    chk("stopbeat_data", mem_wdata, note_in);
    exp_rec.push_back(note_in);
    chk("stopbeat_len", rec_len, 3);
    chk("stopbeat_state", state, 0);
    step();
    chk("stopbeat_wren_off", mem_wren, 0);

    // Asynchronous reset in the middle of a pending handshake.
    note_ready = 1'b0; loop = 1'b0;
    do_start_play();
    beat = 1'b1; step(); beat = 1'b0;
    step(); step();
    chk("pre_rst_valid", note_valid, 1);
    chk("pre_rst_note", note_out, exp_rec[0]);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_valid", note_valid, 0);
    chk("async_rst_len", rec_len, 0);
    chk("async_rst_state", state, 0);
    chk("async_rst_note", note_out, 0);
    #2 resetn = 1'b1;
    step();
    exp_rec.delete();

    // Empty memory cannot be played; start_rec wins a simultaneous request.
    start_play = 1'b1; step(); start_play = 1'b0;
    chk("empty_play_state", state, 0);
    start_play = 1'b1; start_rec = 1'b1; step(); start_play = 1'b0; start_rec = 1'b0;
    chk("both_start_state", state, 1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("both_stop_state", state, 0);
    chk("both_stop_len", rec_len, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
